// File: rtl/m_loader.sv
// UART boot loader: receives a 4-byte little-endian word count followed by that many
// little-endian 32-bit words and writes them to consecutive memory word addresses.
module m_loader #(
  parameter int CLKS_PER_BIT = 434,
  parameter int ADDR_W       = 12
) (
  input  logic              w_clk,
  input  logic              w_rst_n,
  input  logic              w_rxd,
  output logic              r_we,
  output logic [ADDR_W-1:0] r_addr,
  output logic [31:0]       r_wdata,
  output logic              r_busy,
  output logic              r_done,
  output logic              r_err
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0]  HALF_M1 = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0]  FULL_M1 = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0]  CNT_ONE = CNT_W'(1);
  localparam logic [ADDR_W:0]   IDX_ONE = (ADDR_W + 1)'(1);
  localparam logic [32:0]       MAX_N   = 33'(1) << ADDR_W;

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_e;
  typedef enum logic [1:0] {LD_HDR, LD_LOAD, LD_DONE, LD_ERR} ld_state_e;

  logic             rxd_meta_q, rxd_sync_q;
  logic             armed_q, armed_d;
  rx_state_e        rx_state_q, rx_state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bit_q, bit_d;
  logic [7:0]       shift_q, shift_d;
  logic             byte_vld_q, byte_vld_d;
  logic             ferr_q, ferr_d;
  logic             ferr_wait_q, ferr_wait_d;

  ld_state_e        ld_state_q, ld_state_d;
  logic [1:0]       byte_cnt_q, byte_cnt_d;
  logic [31:0]      word_q, word_d;
  logic [31:0]      n_q, n_d;
  logic [ADDR_W:0]  idx_q, idx_d;
  logic             we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]      wdata_q, wdata_d;
  logic [31:0]      assembled;

  // Sync flops reset low so a line held low across reset release is never mistaken for idle.
  always_ff @(posedge w_clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      rxd_meta_q  <= 1'b0;
      rxd_sync_q  <= 1'b0;
      armed_q     <= 1'b0;
      rx_state_q  <= RX_IDLE;
      cnt_q       <= '0;
      bit_q       <= '0;
      shift_q     <= '0;
      byte_vld_q  <= 1'b0;
      ferr_q      <= 1'b0;
      ferr_wait_q <= 1'b0;
    end else begin
      rxd_meta_q  <= w_rxd;
      rxd_sync_q  <= rxd_meta_q;
      armed_q     <= armed_d;
      rx_state_q  <= rx_state_d;
      cnt_q       <= cnt_d;
      bit_q       <= bit_d;
      shift_q     <= shift_d;
      byte_vld_q  <= byte_vld_d;
      ferr_q      <= ferr_d;
      ferr_wait_q <= ferr_wait_d;
    end
  end

  always_comb begin
    armed_d     = armed_q | rxd_sync_q;
    rx_state_d  = rx_state_q;
    cnt_d       = cnt_q;
    bit_d       = bit_q;
    shift_d     = shift_q;
    byte_vld_d  = 1'b0;
    ferr_d      = 1'b0;
    ferr_wait_d = ferr_wait_q;
    case (rx_state_q)
      RX_IDLE: begin
        cnt_d = '0;
        if (armed_q && !rxd_sync_q) rx_state_d = RX_START;
      end
      RX_START: begin
        if (cnt_q == HALF_M1) begin
          cnt_d      = '0;
          bit_d      = '0;
          rx_state_d = rxd_sync_q ? RX_IDLE : RX_DATA;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      RX_DATA: begin
        if (cnt_q == FULL_M1) begin
          cnt_d   = '0;
          shift_d = {rxd_sync_q, shift_q[7:1]};
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7) rx_state_d = RX_STOP;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      RX_STOP: begin
        if (ferr_wait_q) begin
          if (rxd_sync_q) begin
            ferr_wait_d = 1'b0;
            rx_state_d  = RX_IDLE;
          end
        end else if (cnt_q == FULL_M1) begin
          cnt_d = '0;
          if (rxd_sync_q) begin
            byte_vld_d = 1'b1;
            rx_state_d = RX_IDLE;
          end else begin
            ferr_d      = 1'b1;
            ferr_wait_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: rx_state_d = RX_IDLE;
    endcase
  end

  assign assembled = {shift_q, word_q[31:8]};

  always_ff @(posedge w_clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      ld_state_q <= LD_HDR;
      byte_cnt_q <= '0;
      word_q     <= '0;
      n_q        <= '0;
      idx_q      <= '0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
    end else begin
      ld_state_q <= ld_state_d;
      byte_cnt_q <= byte_cnt_d;
      word_q     <= word_d;
      n_q        <= n_d;
      idx_q      <= idx_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
    end
  end

  always_comb begin
    ld_state_d = ld_state_q;
    byte_cnt_d = byte_cnt_q;
    word_d     = word_q;
    n_d        = n_q;
    idx_d      = idx_q;
    we_d       = 1'b0;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    case (ld_state_q)
      LD_HDR: begin
        if (ferr_q) begin
          ld_state_d = LD_ERR;
        end else if (byte_vld_q) begin
          byte_cnt_d = byte_cnt_q + 2'd1;
          word_d     = assembled;
          if (byte_cnt_q == 2'd3) begin
            n_d   = assembled;
            idx_d = '0;
            if (assembled == 32'd0)             ld_state_d = LD_DONE;
            else if ({1'b0, assembled} > MAX_N) ld_state_d = LD_ERR;
            else                                ld_state_d = LD_LOAD;
          end
        end
      end
      LD_LOAD: begin
        if (we_q) begin
          // Index advances as the pulse ends; the final write retires the load here.
          idx_d = idx_q + IDX_ONE;
          if (32'(idx_q) + 32'd1 == n_q) ld_state_d = LD_DONE;
        end else if (ferr_q) begin
          ld_state_d = LD_ERR;
        end else if (byte_vld_q) begin
          byte_cnt_d = byte_cnt_q + 2'd1;
          word_d     = assembled;
          if (byte_cnt_q == 2'd3) begin
            we_d    = 1'b1;
            addr_d  = idx_q[ADDR_W-1:0];
            wdata_d = assembled;
          end
        end
      end
      default: ld_state_d = ld_state_q;
    endcase
  end

  assign r_we    = we_q;
  assign r_addr  = addr_q;
  assign r_wdata = wdata_q;
  assign r_busy  = (ld_state_q != LD_DONE);
  assign r_done  = (ld_state_q == LD_DONE);
  assign r_err   = (ld_state_q == LD_ERR);

endmodule

// File: tb/tb_m_loader.sv
// Bench for m_loader at CLKS_PER_BIT=4: serial frames are driven bit by bit and the
// observed memory writes and status are compared against a byte-stream reference model.
module tb_m_loader;
  localparam int CPB    = 4;
  localparam int ADDR_W = 12;

  logic              w_clk = 1'b0;
  logic              w_rst_n = 1'b0;
  logic              w_rxd = 1'b1;
  logic              r_we;
  logic [ADDR_W-1:0] r_addr;
  logic [31:0]       r_wdata;
  logic              r_busy, r_done, r_err;

  int checks = 0;
  int passes = 0;

  logic [7:0]        tx_bytes[$];
  logic [ADDR_W-1:0] got_addr[$], exp_addr[$];
  logic [31:0]       got_data[$], exp_data[$];
  logic              exp_done, exp_err;

  m_loader #(.CLKS_PER_BIT(CPB), .ADDR_W(ADDR_W)) dut (
    .w_clk(w_clk), .w_rst_n(w_rst_n), .w_rxd(w_rxd),
    .r_we(r_we), .r_addr(r_addr), .r_wdata(r_wdata),
    .r_busy(r_busy), .r_done(r_done), .r_err(r_err)
  );

  always #5 w_clk = ~w_clk;

  always @(negedge w_clk) begin
    if (w_rst_n && r_we) begin
      got_addr.push_back(r_addr);
      got_data.push_back(r_wdata);
      $display("write addr=%0d data=%08h", r_addr, r_wdata);
    end
  end

  task automatic send_bit(input logic b);
    w_rxd = b;
    repeat (CPB) @(negedge w_clk);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(b[i]);
    send_bit(stop);
    w_rxd = 1'b1;
  endtask

  task automatic send_stream();
    foreach (tx_bytes[i]) send_frame(tx_bytes[i], 1'b1);
    repeat (12) @(negedge w_clk);
  endtask

  task automatic do_reset();
    w_rxd   = 1'b1;
    w_rst_n = 1'b0;
    repeat (3) @(negedge w_clk);
    w_rst_n = 1'b1;
    repeat (4) @(negedge w_clk);
    got_addr.delete();
    got_data.delete();
  endtask

  task automatic push_word(input logic [31:0] w);
    for (int i = 0; i < 4; i++) tx_bytes.push_back(w[8*i +: 8]);
  endtask

  // Reference: header gives N; each complete group of 4 following bytes is one word.
  task automatic model_stream();
    logic [31:0] n;
    int avail;
    exp_addr.delete();
    exp_data.delete();
    exp_done = 1'b0;
    exp_err  = 1'b0;
    n = {tx_bytes[3], tx_bytes[2], tx_bytes[1], tx_bytes[0]};
    avail = (tx_bytes.size() - 4) / 4;
    if (n == 32'd0) exp_done = 1'b1;
    else if (n > 32'd4096) exp_err = 1'b1;
    else begin
      for (int k = 0; k < avail && k < int'(n); k++) begin
        exp_addr.push_back(ADDR_W'(k));
        exp_data.push_back({tx_bytes[4*k+7], tx_bytes[4*k+6], tx_bytes[4*k+5], tx_bytes[4*k+4]});
      end
      exp_done = (avail >= int'(n));
    end
  endtask

  task automatic test_reset();
    #2;
    checks++; if (r_we !== 1'b0) $display("FAIL reset we: got %b want 0", r_we); else passes++;
    checks++; if (r_addr !== '0) $display("FAIL reset addr: got %0h want 0", r_addr); else passes++;
    checks++; if (r_wdata !== '0) $display("FAIL reset wdata: got %0h want 0", r_wdata); else passes++;
    checks++; if (r_busy !== 1'b1) $display("FAIL reset busy: got %b want 1", r_busy); else passes++;
    checks++; if (r_done !== 1'b0) $display("FAIL reset done: got %b want 0", r_done); else passes++;
    checks++; if (r_err !== 1'b0) $display("FAIL reset err: got %b want 0", r_err); else passes++;
  endtask

  task automatic test_load(input string name);
    do_reset();
    send_stream();
    model_stream();
    checks++;
    if (got_addr.size() != exp_addr.size())
      $display("FAIL %s count: got %0d writes want %0d", name, got_addr.size(), exp_addr.size());
    else passes++;
    for (int i = 0; i < exp_addr.size() && i < got_addr.size(); i++) begin
      checks++;
      if (got_addr[i] !== exp_addr[i] || got_data[i] !== exp_data[i])
        $display("FAIL %s write%0d: got %0d/%08h want %0d/%08h", name, i,
                 got_addr[i], got_data[i], exp_addr[i], exp_data[i]);
      else passes++;
    end
    checks++;
    if (r_done !== exp_done || r_err !== exp_err || r_busy !== !exp_done)
      $display("FAIL %s status: got done=%b err=%b busy=%b want done=%b err=%b busy=%b",
               name, r_done, r_err, r_busy, exp_done, exp_err, !exp_done);
    else passes++;
  endtask

  task automatic test_two_words();
    tx_bytes = '{8'h02, 8'h00, 8'h00, 8'h00};
    push_word(32'h12345678);
    push_word(32'hDEADBEEF);
    test_load("two_words");
    checks++; if (got_data.size() != 2 || got_data[1] !== 32'hDEADBEEF)
      $display("FAIL two_words literal: got %0d writes want 2 ending deadbeef", got_data.size());
    else passes++;
  endtask

  task automatic test_zero_header();
    tx_bytes = '{8'h00, 8'h00, 8'h00, 8'h00};
    push_word(32'hCAFEF00D);
    test_load("zero_header");
  endtask

  task automatic test_oversize();
    tx_bytes = '{8'h01, 8'h10, 8'h00, 8'h00};
    push_word(32'h01020304);
    push_word(32'hA5A5A5A5);
    test_load("oversize");
  endtask

  task automatic test_random_loads();
    for (int it = 0; it < 4; it++) begin
      int n;
      n = $urandom_range(1, 3);
      tx_bytes = '{8'(n), 8'h00, 8'h00, 8'h00};
      for (int k = 0; k < n; k++) push_word($urandom);
      if (it == 3) push_word($urandom);
      test_load("random_load");
    end
  endtask

  task automatic test_framing();
    do_reset();
    send_frame(8'h01, 1'b1); send_frame(8'h00, 1'b1);
    send_frame(8'h00, 1'b1); send_frame(8'h00, 1'b1);
    send_frame(8'h11, 1'b1);
    send_frame(8'h22, 1'b0);
    repeat (6) @(negedge w_clk);
    for (int i = 0; i < 8; i++) send_frame(8'($urandom), 1'b1);
    repeat (12) @(negedge w_clk);
    checks++; if (got_addr.size() != 0) $display("FAIL framing writes: got %0d want 0", got_addr.size()); else passes++;
    checks++; if (r_err !== 1'b1 || r_busy !== 1'b1 || r_done !== 1'b0)
      $display("FAIL framing status: got err=%b busy=%b done=%b want 1 1 0", r_err, r_busy, r_done);
    else passes++;
  endtask

  task automatic test_glitch();
    do_reset();
    w_rxd = 1'b0;
    @(negedge w_clk);
    w_rxd = 1'b1;
    repeat (20) @(negedge w_clk);
    checks++; if (r_err !== 1'b0 || r_done !== 1'b0)
      $display("FAIL glitch status: got err=%b done=%b want 0 0", r_err, r_done);
    else passes++;
    tx_bytes = '{8'h01, 8'h00, 8'h00, 8'h00};
    push_word($urandom);
    send_stream();
    model_stream();
    checks++; if (got_addr.size() != 1 || got_addr[0] !== 0 || got_data[0] !== exp_data[0])
      $display("FAIL glitch load: got %0d writes want 1 at addr 0 data %08h", got_addr.size(), exp_data[0]);
    else passes++;
  endtask

  task automatic test_reset_midload();
    logic [31:0] w1;
    do_reset();
    tx_bytes = '{8'h02, 8'h00, 8'h00, 8'h00};
    push_word(32'h0BADC0DE);
    foreach (tx_bytes[i]) send_frame(tx_bytes[i], 1'b1);
    send_frame(8'h44, 1'b1);
    send_frame(8'h55, 1'b1);
    send_bit(1'b0); send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
    checks++; if (got_addr.size() != 1 || got_data[0] !== 32'h0BADC0DE)
      $display("FAIL midload first: got %0d writes want 1 of 0badc0de", got_addr.size());
    else passes++;
    @(posedge w_clk);
    #2 w_rst_n = 1'b0;
    #1;
    checks++; if (r_we !== 1'b0 || r_addr !== '0 || r_wdata !== '0)
      $display("FAIL midload async: got we=%b addr=%0h wdata=%08h want 0 0 0", r_we, r_addr, r_wdata);
    else passes++;
    checks++; if (r_busy !== 1'b1 || r_done !== 1'b0 || r_err !== 1'b0)
      $display("FAIL midload flags: got busy=%b done=%b err=%b want 1 0 0", r_busy, r_done, r_err);
    else passes++;
    w1 = $urandom;
    tx_bytes = '{8'h01, 8'h00, 8'h00, 8'h00};
    push_word(w1);
    do_reset();
    send_stream();
    checks++; if (got_addr.size() != 1 || got_addr[0] !== 0 || got_data[0] !== w1 || r_done !== 1'b1)
      $display("FAIL midload reload: got %0d writes done=%b want 1 write of %08h at 0", got_addr.size(), r_done, w1);
    else passes++;
  endtask

  task automatic test_low_line_release();
    w_rxd   = 1'b0;
    w_rst_n = 1'b0;
    repeat (3) @(negedge w_clk);
    w_rst_n = 1'b1;
    repeat (50) @(negedge w_clk);
    w_rxd = 1'b1;
    repeat (10) @(negedge w_clk);
    tx_bytes = '{8'h00, 8'h00, 8'h00, 8'h00};
    send_stream();
    checks++; if (r_done !== 1'b1 || r_err !== 1'b0)
      $display("FAIL low_line status: got done=%b err=%b want 1 0", r_done, r_err);
    else passes++;
  endtask

  initial begin
    test_reset();
    test_two_words();
    test_zero_header();
    test_oversize();
    test_random_loads();
    test_framing();
    test_glitch();
    test_reset_midload();
    test_low_line_release();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL timeout: simulation did not finish, %0d/%0d so far", passes, checks);
    $fatal(1);
  end
endmodule
